axil_sram_slave: RTL and testbench

//  AXI4-Lite memory responder: the target side of the core's instruction-fetch and load/store requests.

---
 rtl/npc_axil_pkg.sv | 16 +
 rtl/axil_sram_slave_if.sv | 41 ++++
 rtl/axil_sram_slave_lfsr8.sv | 19 +
 rtl/axil_sram_slave.sv | 164 ++++++++++++++++
 tb/tb_axil_sram_slave.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npc_axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and responder FSM states.
// Used by axil_sram_slave and the ifu/lsu initiators.
package npc_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_RESP = 3'd2,
        WR_WAIT = 3'd3,
        WR_RESP = 3'd4
    } axilState_e;

endpackage

// File: rtl/axil_sram_slave_if.sv
// AXI4-Lite bus bundle between an initiator (master) and a responder (slave).
// Address/data widths are parameters; strobe width is DATA_WIDTH/8.
interface axil_sram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import npc_axil_pkg::*;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/axil_sram_slave_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seeded with 8'hA5.
// Advances only when step is high; drives the random response delay.
module lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output logic [7:0] q
);

    // Shift in the tap parity on each step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 8'hA5;
        end else if (step) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/axil_sram_slave.sv
// AXI4-Lite SRAM responder: one transaction at a time, programmable latency.
// Define AXIL_SRAM_RAND_DELAY_EN to add an LFSR-driven random extra delay.
module axil_sram_slave
    import npc_axil_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    LATENCY    = 1
) (
    input logic              clk,
    input logic              rst,
    axil_sram_slave_if.slave bus
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    axilState_e stateQ;
    axilState_e stateD;

    logic [4:0]            cntQ;
    logic [4:0]            delay;
    logic                  prefWrite;
    logic [DATA_WIDTH-1:0] rdataQ;
    logic [1:0]            rrespQ;
    logic [1:0]            brespQ;

    logic arreadyD;
    logic wrReadyD;
    logic rdAccept;
    logic wrAccept;
    logic wrOffer;

    logic [ADDR_WIDTH-1:0] rdOff;
    logic [ADDR_WIDTH-1:0] wrOff;
    logic [DEPTH_LOG2-1:0] rdIdx;
    logic [DEPTH_LOG2-1:0] wrIdx;
    logic                  rdInRange;
    logic                  wrInRange;

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Word index relative to BASE_ADDR; the byte offset bits are don't-care.
    assign rdOff = bus.araddr - BASE_ADDR;
    assign wrOff = bus.awaddr - BASE_ADDR;
    assign rdIdx = rdOff[DEPTH_LOG2+1:2];
    assign wrIdx = wrOff[DEPTH_LOG2+1:2];

    assign rdInRange = (bus.araddr >= BASE_ADDR)
                    && (rdOff[ADDR_WIDTH-1:DEPTH_LOG2+2] == '0);
    assign wrInRange = (bus.awaddr >= BASE_ADDR)
                    && (wrOff[ADDR_WIDTH-1:DEPTH_LOG2+2] == '0);

`ifdef AXIL_SRAM_RAND_DELAY_EN
    logic [7:0] lfsrQ;
    logic       unusedBits;

    lfsr8 uLfsr (
        .clk  (clk),
        .rst  (rst),
        .step (rdAccept | wrAccept),
        .q    (lfsrQ)
    );

    assign delay      = 5'(LATENCY) + {1'b0, lfsrQ[3:0]};
    assign unusedBits = ^{rdOff[1:0], wrOff[1:0], lfsrQ[7:4]};
`else
    logic unusedBits;

    assign delay      = 5'(LATENCY);
    assign unusedBits = ^{rdOff[1:0], wrOff[1:0]};
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next state, arbitration and handshake readies.
    always_comb begin
        stateD   = stateQ;
        arreadyD = 1'b0;
        wrReadyD = 1'b0;
        rdAccept = 1'b0;
        wrAccept = 1'b0;
        wrOffer  = bus.awvalid & bus.wvalid;
        unique case (stateQ)
            IDLE: begin
                arreadyD = !rst && !(wrOffer && prefWrite);
                wrReadyD = !rst && wrOffer
                        && !(bus.arvalid && !prefWrite);
                if (bus.arvalid && arreadyD) begin
                    rdAccept = 1'b1;
                    stateD   = (delay == 5'd0) ? RD_RESP : RD_WAIT;
                end else if (wrReadyD) begin
                    wrAccept = 1'b1;
                    stateD   = (delay == 5'd0) ? WR_RESP : WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (cntQ <= 5'd1) stateD = RD_RESP;
            end
            RD_RESP: begin
                if (bus.rready) stateD = IDLE;
            end
            WR_WAIT: begin
                if (cntQ <= 5'd1) stateD = WR_RESP;
            end
            WR_RESP: begin
                if (bus.bready) stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    // Response capture, delay counter and round-robin flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdataQ    <= '0;
            rrespQ    <= RESP_OKAY;
            brespQ    <= RESP_OKAY;
            cntQ      <= '0;
            prefWrite <= 1'b0;
        end else if (rdAccept) begin
            rdataQ    <= rdInRange ? mem[rdIdx] : '0;
            rrespQ    <= rdInRange ? RESP_OKAY : RESP_SLVERR;
            cntQ      <= delay;
            prefWrite <= 1'b1;
        end else if (wrAccept) begin
            brespQ    <= wrInRange ? RESP_OKAY : RESP_SLVERR;
            cntQ      <= delay;
            prefWrite <= 1'b0;
        end else if ((stateQ == RD_WAIT || stateQ == WR_WAIT)
                     && cntQ != 5'd0) begin
            cntQ <= cntQ - 5'd1;
        end
    end

    // Byte-strobed array write on the acceptance edge; array is never reset.
    always_ff @(posedge clk) begin
        if (wrAccept && wrInRange) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (bus.wstrb[i]) begin
                    mem[wrIdx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.arready = arreadyD;
    assign bus.awready = wrReadyD;
    assign bus.wready  = wrReadyD;
    assign bus.rdata   = rdataQ;
    assign bus.rresp   = rrespQ;
    assign bus.rvalid  = (stateQ == RD_RESP);
    assign bus.bresp   = brespQ;
    assign bus.bvalid  = (stateQ == WR_RESP);

endmodule

// File: tb/tb_axil_sram_slave.sv
// Testbench for axil_sram_slave: vector table through a scoreboard,
// plus hand-written arbitration, backpressure and reset sequences.
module tb_axil_sram_slave;
    import npc_axil_pkg::*;

    typedef struct {
        bit          isWr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] expData;
        logic [1:0]  expResp;
    } vec_t;

    typedef struct {
        bit          isWr;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int compared   = 0;
    int mismatched = 0;
    int minLat     = 1000;
    int maxLat     = 0;

    exp_t sbq[$];
    vec_t vecs[16];

    axil_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axil_sram_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH_LOG2 (16),
        .BASE_ADDR  (32'h8000_0000),
        .LATENCY    (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkLat(input string name, input int n);
        if (n < minLat) minLat = n;
        if (n > maxLat) maxLat = n;
`ifdef AXIL_SRAM_RAND_DELAY_EN
        compared++;
        if (n < 2 || n > 17) begin
            mismatched++;
            $display("FAIL %s: got %0d expected 2..17", name, n);
        end
`else
        check(name, n, 2);
`endif
    endtask

    task automatic runXact(input vec_t v, input string tag);
        int   n;
        bit   got;
        exp_t e;
        @(negedge clk);
        if (v.isWr) begin
            bus.awaddr  = v.addr;
            bus.wdata   = v.wdata;
            bus.wstrb   = v.strb;
            bus.awvalid = 1'b1;
            bus.wvalid  = 1'b1;
        end else begin
            bus.araddr  = v.addr;
            bus.arvalid = 1'b1;
        end
        #1;
        n = 0;
        while (!(v.isWr ? bus.awready : bus.arready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            check({tag, "_accept_timeout"}, 0, 1);
            bus.arvalid = 1'b0;
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
            return;
        end
        @(posedge clk);
        sbq.push_back('{v.isWr, v.expData, v.expResp});
        #1;
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        n   = 0;
        got = 0;
        repeat (40) begin
            @(negedge clk);
            n++;
            if (v.isWr ? bus.bvalid : bus.rvalid) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            check({tag, "_resp_timeout"}, 0, 1);
            void'(sbq.pop_front());
            return;
        end
        checkLat({tag, "_lat"}, n);
        e = sbq.pop_front();
        if (e.isWr) begin
            check({tag, "_bresp"}, 32'(bus.bresp), 32'(e.resp));
            bus.bready = 1'b1;
        end else begin
            check({tag, "_rresp"}, 32'(bus.rresp), 32'(e.resp));
            check({tag, "_rdata"}, bus.rdata, e.data);
            bus.rready = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.rready = 1'b0;
        bus.bready = 1'b0;
    endtask

    initial begin
        int  n;
        bit  bad;
        bit  got;

        vecs[0]  = '{1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, RESP_OKAY};
        vecs[1]  = '{0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, RESP_OKAY};
        vecs[2]  = '{1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0, RESP_OKAY};
        vecs[3]  = '{1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 32'h0, RESP_OKAY};
        vecs[4]  = '{0, 32'h8000_0020, 32'h0, 4'h0, 32'h11BB_33DD, RESP_OKAY};
        vecs[5]  = '{0, 32'h0000_1000, 32'h0, 4'h0, 32'h0, RESP_SLVERR};
        vecs[6]  = '{1, 32'h8000_1000, 32'hCAFE_F00D, 4'hF, 32'h0, RESP_OKAY};
        vecs[7]  = '{1, 32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0, RESP_SLVERR};
        vecs[8]  = '{0, 32'h8000_1000, 32'h0, 4'h0, 32'hCAFE_F00D, RESP_OKAY};
        vecs[9]  = '{0, 32'h8000_1003, 32'h0, 4'h0, 32'hCAFE_F00D, RESP_OKAY};
        vecs[10] = '{1, 32'h8003_FFFC, 32'h0BAD_C0DE, 4'hF, 32'h0, RESP_OKAY};
        vecs[11] = '{0, 32'h8003_FFFC, 32'h0, 4'h0, 32'h0BAD_C0DE, RESP_OKAY};
        vecs[12] = '{0, 32'h8004_0000, 32'h0, 4'h0, 32'h0, RESP_SLVERR};
        vecs[13] = '{0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, RESP_SLVERR};
        vecs[14] = '{1, 32'h8000_0010, 32'h77FF_FFFF, 4'h8, 32'h0, RESP_OKAY};
        vecs[15] = '{0, 32'h8000_0010, 32'h0, 4'h0, 32'h77AD_BEEF, RESP_OKAY};

        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        bus.awaddr  = '0;
        bus.awvalid = 1'b1;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b1;

        // Reset state with requests offered.
        repeat (2) @(negedge clk);
        #1;
        check("rst_arready", 32'(bus.arready), 0);
        check("rst_awready", 32'(bus.awready), 0);
        check("rst_wready", 32'(bus.wready), 0);
        check("rst_rvalid", 32'(bus.rvalid), 0);
        check("rst_bvalid", 32'(bus.bvalid), 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_resp", 32'({bus.rresp, bus.bresp}), 0);
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_arready", 32'(bus.arready), 1);

        // Table-driven vectors.
        for (int i = 0; i < 16; i++) begin
            runXact(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: rready low for 5 cycles with a new read offered.
        @(negedge clk);
        bus.araddr  = 32'h8000_0010;
        bus.arvalid = 1'b1;
        @(posedge clk);
        #1;
        got = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.rvalid) begin
                got = 1;
                break;
            end
        end
        check("bp_rvalid_seen", 32'(got), 1);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h77AD_BEEF
                || bus.arready !== 1'b0) bad = 1;
        end
        check("bp_hold_stable", 32'(bad), 0);
        bus.rready = 1'b1;
        @(posedge clk);
        #1;
        bus.rready = 1'b0;
        @(negedge clk);
        #1;
        check("bp_idle_rvalid", 32'(bus.rvalid), 0);
        check("bp_idle_arready", 32'(bus.arready), 1);
        bus.arvalid = 1'b0;

        // Arbitration after reset: read first, then write.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.araddr  = 32'h8000_0010;
        bus.arvalid = 1'b1;
        bus.awaddr  = 32'h8000_0050;
        bus.wdata   = 32'h5566_7788;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        #1;
        check("arb_arready", 32'(bus.arready), 1);
        check("arb_awready", 32'({bus.awready, bus.wready}), 0);
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        got = 0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.awready) bad = 1;
            if (bus.rvalid) begin
                got = 1;
                break;
            end
        end
        check("arb_rd_first", 32'({got, bad}), 32'h2);
        check("arb_rdata", bus.rdata, 32'h77AD_BEEF);
        bus.rready = 1'b1;
        @(posedge clk);
        #1;
        bus.rready = 1'b0;
        @(negedge clk);
        #1;
        check("arb_wr_next", 32'({bus.awready, bus.wready}), 32'h3);
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        n   = 0;
        got = 0;
        repeat (40) begin
            @(negedge clk);
            n++;
            if (bus.bvalid) begin
                got = 1;
                break;
            end
        end
        check("arb_bvalid_seen", 32'(got), 1);
        checkLat("arb_wr_lat", n);
        check("arb_bresp", 32'(bus.bresp), 32'(RESP_OKAY));
        bus.bready = 1'b1;
        @(posedge clk);
        #1;
        bus.bready = 1'b0;
        @(negedge clk);
        bus.arvalid = 1'b1;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        #1;
        check("rr_read_turn", 32'({bus.arready, bus.awready}), 32'h2);
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        runXact('{0, 32'h8000_0050, 32'h0, 4'h0, 32'h5566_7788, RESP_OKAY},
                "arb_readback");

        // Reset while a read is waiting.
        @(negedge clk);
        bus.araddr  = 32'h8000_0020;
        bus.arvalid = 1'b1;
        #1;
        check("rstmid_arready", 32'(bus.arready), 1);
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_rvalid", 32'(bus.rvalid), 0);
        check("rstmid_arready_low", 32'(bus.arready), 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rvalid !== 1'b0) bad = 1;
        end
        check("rstmid_dropped", 32'(bad), 0);
        runXact('{0, 32'h8000_0020, 32'h0, 4'h0, 32'h11BB_33DD, RESP_OKAY},
                "rstmid_fresh");

`ifdef AXIL_SRAM_RAND_DELAY_EN
        compared++;
        if (minLat == maxLat) begin
            mismatched++;
            $display("FAIL rand_delay_varies: got %0d..%0d expected spread",
                     minLat, maxLat);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
